// File: rtl/noc_axi4_bridge_pkg.sv
// Shared types and defaults for the NoC-to-AXI4 bridge flit arbiter.
// Latency: n/a (types only); backpressure: n/a.
`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 64
`endif
`ifndef MSG_LENGTH
`define MSG_LENGTH 29:22
`endif
`ifndef MSG_LENGTH_WIDTH
`define MSG_LENGTH_WIDTH 8
`endif

package noc_axi4_bridge_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    localparam int NUM_PORTS_DEF = 3;

endpackage

// File: rtl/noc_axi4_bridge_rr_pick.sv
// Rotating-priority pick: first set req bit searching from ptr+1 upward, modulo N.
// Latency: combinational; backpressure: none, pure function of req/ptr.
module noc_axi4_bridge_rr_pick #(
    parameter int N = 3,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] gnt_idx,
    output logic         gnt_any
);

    int idx;

    // Walk from the farthest candidate back to the nearest so the nearest hit wins.
    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(ptr) + k) % N;
            if (req[idx]) begin
                gnt_idx = W'(idx);
                gnt_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/noc_axi4_bridge_flit_arb.sv
// Round-robin flit arbiter locking the deserializer to one port for a whole packet.
// Latency: 0 cycles, no buffering; backpressure: out_rdy passes straight to the granted port's in_rdy.
`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 64
`endif
`ifndef MSG_LENGTH
`define MSG_LENGTH 29:22
`endif
`ifndef MSG_LENGTH_WIDTH
`define MSG_LENGTH_WIDTH 8
`endif

module noc_axi4_bridge_flit_arb
    import noc_axi4_bridge_pkg::*;
#(
    parameter int NUM_PORTS = NUM_PORTS_DEF,
    parameter int PORT_W    = $clog2(NUM_PORTS)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_PORTS*`NOC_DATA_WIDTH-1:0]  in_flit,
    input  logic [NUM_PORTS-1:0]                  in_val,
    output logic [NUM_PORTS-1:0]                  in_rdy,
    output logic [`NOC_DATA_WIDTH-1:0]            out_flit,
    output logic                                  out_val,
    input  logic                                  out_rdy,
    output logic [PORT_W-1:0]                     out_port,
    output logic                                  busy
);

    localparam int DW = `NOC_DATA_WIDTH;
    localparam int LW = `MSG_LENGTH_WIDTH;

    arb_state_t         state_q, state_d;
    logic [PORT_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [PORT_W-1:0]  port_q, port_d;
    logic [LW-1:0]      remaining_q, remaining_d;

    logic [PORT_W-1:0]  pick_idx;
    logic               pick_any;
    logic [PORT_W-1:0]  gnt;
    logic               owned;
    logic               xfer;
    logic [DW-1:0]      sel_flit;

    noc_axi4_bridge_rr_pick #(
        .N (NUM_PORTS),
        .W (PORT_W)
    ) u_pick (
        .req     (in_val),
        .ptr     (rr_ptr_q),
        .gnt_idx (pick_idx),
        .gnt_any (pick_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= PORT_W'(NUM_PORTS - 1);
            port_q      <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            port_q      <= port_d;
            remaining_q <= remaining_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        port_d      = port_q;
        remaining_d = remaining_q;
        gnt         = (state_q == LOCK) ? port_q : pick_idx;
        owned       = (state_q == LOCK) || pick_any;
        sel_flit    = in_flit[int'(gnt)*DW +: DW];
        out_flit    = sel_flit;
        out_val     = 1'b0;
        in_rdy      = '0;
        out_port    = rst ? '0 : port_q;

        if (!rst && owned) begin
            out_val     = in_val[gnt];
            in_rdy[gnt] = out_rdy;
            out_port    = gnt;
        end
        xfer = out_val && out_rdy;

        case (state_q)
            IDLE: begin
                // port_q tracks the displayed choice so out_port holds it when nobody requests.
                if (pick_any) begin
                    port_d = pick_idx;
                end
                if (xfer) begin
                    rr_ptr_d    = gnt;
                    remaining_d = sel_flit[`MSG_LENGTH];
                    if (sel_flit[`MSG_LENGTH] != '0) begin
                        state_d = LOCK;
                    end
                end
            end
            LOCK: begin
                if (xfer) begin
                    if (remaining_q != '0) begin
                        remaining_d = remaining_q - LW'(1);
                    end
                    if (remaining_q <= LW'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy = (state_q == LOCK);
    end

endmodule

// File: tb/tb_noc_axi4_bridge_flit_arb.sv
// Bench for the flit arbiter: directed packet scenarios plus 10k random packets against a packet-level model.
`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 64
`endif
`ifndef MSG_LENGTH
`define MSG_LENGTH 29:22
`endif
`ifndef MSG_LENGTH_WIDTH
`define MSG_LENGTH_WIDTH 8
`endif

module tb_noc_axi4_bridge_flit_arb;

    localparam int NP    = 3;
    localparam int PW    = $clog2(NP);
    localparam int DW    = `NOC_DATA_WIDTH;
    localparam int NPKT  = 10000;
    localparam int LIMIT = 80000;

    logic               clk = 1'b0;
    logic               rst;
    logic [NP*DW-1:0]   in_flit;
    logic [NP-1:0]      in_val;
    logic [NP-1:0]      in_rdy;
    logic [DW-1:0]      out_flit;
    logic               out_val;
    logic               out_rdy;
    logic [PW-1:0]      out_port;
    logic               busy;

    logic [DW-1:0]      drv_flit [NP];

    always #5 clk = ~clk;

    always_comb begin
        in_flit = '0;
        for (int i = 0; i < NP; i++) in_flit[i*DW +: DW] = drv_flit[i];
    end

    noc_axi4_bridge_flit_arb #(.NUM_PORTS(NP)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_flit  (in_flit),
        .in_val   (in_val),
        .in_rdy   (in_rdy),
        .out_flit (out_flit),
        .out_val  (out_val),
        .out_rdy  (out_rdy),
        .out_port (out_port),
        .busy     (busy)
    );

    int n_chk = 0;
    int n_err = 0;

    // Packet-level model: flits still owed by the current packet, its owner, last winner.
    int m_left = 0;
    int m_owner = 0;
    int m_last = NP - 1;
    int m_hold = 0;
    int wait_cnt [NP];
    bit m_xfer;
    int m_xport;
    int cyc = 0;

    logic [PW-1:0] obs_port;
    logic [NP-1:0] obs_rdy;
    logic          obs_val;
    logic          obs_busy;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int rr_first(input logic [NP-1:0] v, input int last);
        for (int k = 1; k <= NP; k++) begin
            if (v[(last + k) % NP]) return (last + k) % NP;
        end
        return -1;
    endfunction

    function automatic logic [DW-1:0] mk(input int port, input int seq, input int idx, input int len);
        logic [DW-1:0] f;
        f = {$urandom, $urandom};
        f[63:32] = {8'(port), 16'(seq), 8'(idx)};
        f[`MSG_LENGTH] = `MSG_LENGTH_WIDTH'(len);
        return f;
    endfunction

    task automatic step(input logic [NP-1:0] v, input logic rdy);
        int own;
        int exp_port;
        logic exp_val;
        logic [NP-1:0] exp_rdy;
        in_val  = v;
        out_rdy = rdy;
        #2;
        own      = (m_left > 0) ? m_owner : rr_first(v, m_last);
        exp_val  = 1'b0;
        exp_rdy  = '0;
        exp_port = m_hold;
        if (rst) exp_port = 0;
        else if (own >= 0) begin
            exp_val      = v[own];
            exp_rdy[own] = rdy;
            exp_port     = own;
        end
        obs_port = out_port;
        obs_rdy  = in_rdy;
        obs_val  = out_val;
        obs_busy = busy;
        chk_eq("out_val", out_val, exp_val);
        chk_eq("in_rdy", in_rdy, exp_rdy);
        chk_eq("out_port", out_port, exp_port);
        if (!rst) chk_eq("busy", busy, m_left > 0);
        if (exp_val) chk_eq("out_flit", out_flit, drv_flit[own]);
        m_xfer  = exp_val && rdy;
        m_xport = own;
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            m_left = 0;
            m_last = NP - 1;
            m_hold = 0;
            m_xfer = 1'b0;
            for (int i = 0; i < NP; i++) wait_cnt[i] = 0;
        end else begin
            if (own >= 0) m_hold = own;
            if (m_xfer) begin
                if (m_left == 0) begin
                    chk_eq("starve", wait_cnt[own] <= NP - 1, 1);
                    for (int i = 0; i < NP; i++) begin
                        if (i == own) wait_cnt[i] = 0;
                        else if (v[i]) wait_cnt[i]++;
                        else wait_cnt[i] = 0;
                    end
                    m_last  = own;
                    m_owner = own;
                    m_left  = int'(drv_flit[own][`MSG_LENGTH]);
                end else begin
                    m_left--;
                end
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step('1, 1'b1);
        step('1, 1'b1);
        rst = 1'b0;
    endtask

    logic [DW-1:0] fq [NP][$];
    int seq_exp [4] = '{0, 1, 2, 0};
    int total_flits = 0;
    int delivered = 0;
    int pending;
    logic [NP-1:0] rv;

    initial begin
        rst     = 1'b0;
        in_val  = '0;
        out_rdy = 1'b0;
        for (int i = 0; i < NP; i++) begin
            drv_flit[i] = '0;
            wait_cnt[i] = 0;
        end
        @(posedge clk);
        #1;

        // Equal priority, single-flit packets: pure rotation from port 0.
        do_reset();
        for (int i = 0; i < NP; i++) drv_flit[i] = mk(i, i, 0, 0);
        for (int c = 0; c < 4; c++) begin
            step(3'b111, 1'b1);
            chk_eq("rot_seq", obs_port, seq_exp[c]);
        end

        // Port 1 locks for three flits while port 0 keeps requesting.
        do_reset();
        drv_flit[0] = mk(0, 10, 0, 0);
        step(3'b001, 1'b1);
        drv_flit[1] = mk(1, 11, 0, 2);
        step(3'b011, 1'b1);
        chk_eq("lock_hdr_port", obs_port, 1);
        for (int b = 1; b <= 2; b++) begin
            drv_flit[1] = mk(1, 11, b, 7);
            step(3'b011, 1'b1);
            chk_eq("lock_body_port", obs_port, 1);
            chk_eq("lock_rdy0", obs_rdy[0], 1'b0);
            chk_eq("lock_busy", obs_busy, 1'b1);
        end
        step(3'b011, 1'b1);
        chk_eq("after_lock_port", obs_port, 0);

        // Port 2 locked with two body flits outstanding, valid dropped for three cycles.
        do_reset();
        drv_flit[2] = mk(2, 20, 0, 2);
        step(3'b100, 1'b1);
        for (int c = 0; c < 3; c++) begin
            step(3'b000, 1'b1);
            chk_eq("gap_val", obs_val, 1'b0);
            chk_eq("gap_busy", obs_busy, 1'b1);
        end
        drv_flit[2] = mk(2, 20, 1, 0);
        step(3'b100, 1'b1);
        drv_flit[2] = mk(2, 20, 2, 0);
        step(3'b100, 1'b1);
        chk_eq("gap_last_busy", obs_busy, 1'b1);
        step(3'b000, 1'b1);
        chk_eq("gap_done_busy", obs_busy, 1'b0);

        // Downstream stall for five cycles mid-packet.
        do_reset();
        drv_flit[0] = mk(0, 30, 0, 3);
        drv_flit[2] = mk(2, 32, 0, 0);
        drv_flit[1] = mk(1, 31, 0, 0);
        step(3'b111, 1'b1);
        drv_flit[0] = mk(0, 30, 1, 0);
        step(3'b111, 1'b1);
        for (int c = 0; c < 5; c++) begin
            step(3'b111, 1'b0);
            chk_eq("stall_rdy", obs_rdy, 3'b000);
            chk_eq("stall_busy", obs_busy, 1'b1);
            chk_eq("stall_port", obs_port, 0);
        end
        drv_flit[0] = mk(0, 30, 2, 0);
        step(3'b111, 1'b1);
        drv_flit[0] = mk(0, 30, 3, 0);
        step(3'b111, 1'b1);
        chk_eq("stall_tail_busy", obs_busy, 1'b1);
        step(3'b111, 1'b1);
        chk_eq("stall_next_port", obs_port, 1);

        // Reset in the middle of a five-flit body.
        do_reset();
        drv_flit[0] = mk(0, 40, 0, 5);
        step(3'b001, 1'b1);
        rst = 1'b1;
        step(3'b001, 1'b1);
        rst = 1'b0;
        step(3'b000, 1'b1);
        chk_eq("rst_busy", obs_busy, 1'b0);
        drv_flit[1] = mk(1, 41, 0, 0);
        step(3'b010, 1'b1);
        chk_eq("rst_port", obs_port, 1);
        chk_eq("rst_rdy", obs_rdy, 3'b010);

        // Random traffic: 10k packets, lengths 0..8.
        do_reset();
        for (int p = 0; p < NPKT; p++) begin
            int port;
            int len;
            port = p % NP;
            len  = $urandom_range(0, 8);
            fq[port].push_back(mk(port, p, 0, len));
            for (int k = 1; k <= len; k++) fq[port].push_back(mk(port, p, k, $urandom_range(0, 255)));
            total_flits += len + 1;
        end
        pending = total_flits;
        while (pending > 0 && cyc < LIMIT) begin
            for (int i = 0; i < NP; i++) begin
                rv[i] = (fq[i].size() > 0) && ($urandom_range(0, 99) < 95);
                drv_flit[i] = (fq[i].size() > 0) ? fq[i][0] : {$urandom, $urandom};
            end
            step(rv, $urandom_range(0, 99) < 95);
            if (m_xfer) begin
                void'(fq[m_xport].pop_front());
                delivered++;
                pending--;
            end
        end
        chk_eq("rand_timeout", cyc >= LIMIT, 1'b0);
        chk_eq("rand_delivered", delivered, total_flits);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
